mult_exec_unit: RTL and testbench

//  Pipelined 16x16 multiply execution unit, directly downstream of the multiply issue queue.

---
 rtl/mult_exec_unit.sv | 118 +++++++++++
 tb/tb_mult_exec_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_exec_unit.sv
// Pipelined 16x16 multiply unit: N_STAGES elastic stages from issue queue to CDB request.
// Optional MULT_SIGNED_EN selects a signed product (low 16 bits unchanged).
module mult_exec_unit #(
  parameter int N_STAGES = 4,
  parameter int OCC_W    = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IssueQue_Ready,
  input  logic [15:0]       IssueQue_Rs_Data,
  input  logic [15:0]       IssueQue_Rt_Data,
  input  logic [4:0]        IssueQue_Rd_Tag,
  input  logic              Issueblk_Issue,
  output logic              Mult_Ready,
  output logic              Mult_Cdb_Req,
  output logic [15:0]       Mult_Cdb_Data,
  output logic [4:0]        Mult_Cdb_Tag,
  input  logic              Cdb_Grant,
  input  logic              RB_Flush_Valid,
  output logic [OCC_W-1:0]  Mult_Occupancy
);

  localparam int K = N_STAGES - 1;

  logic [N_STAGES-1:0] r_v;
  logic [N_STAGES-1:0] w_v_nxt;
  logic [N_STAGES-1:0] w_adv;
  logic [15:0]         r_rs;
  logic [15:0]         r_rt;
  logic [4:0]          r_tag  [N_STAGES];
  logic [15:0]         r_prod [1:N_STAGES-1];
  logic [OCC_W-1:0]    r_occ;
  logic [OCC_W-1:0]    w_occ_nxt;
  logic [31:0]         w_prod32;
  logic                w_ready;
  logic                w_load;
  logic                w_unused_hi;

`ifdef MULT_SIGNED_EN
  assign w_prod32 = $signed({{16{r_rs[15]}}, r_rs}) * $signed({{16{r_rt[15]}}, r_rt});
`else
  assign w_prod32 = {16'b0, r_rs} * {16'b0, r_rt};
`endif
  assign w_unused_hi = ^w_prod32[31:16];

  // adv[i] = grant or a hole somewhere in stages i..K; the extra ~v[i] term is
  // harmless because adv[i] is only ever used qualified by v[i] or ORed with ~v[0].
  always_comb begin
    logic l_full;
    l_full = 1'b1;
    w_adv  = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      l_full   = l_full & r_v[i];
      w_adv[i] = Cdb_Grant | ~l_full;
    end
  end

  assign w_ready = ~r_v[0] | w_adv[0];
  assign w_load  = Issueblk_Issue & IssueQue_Ready & w_ready;

  always_comb begin
    w_v_nxt   = '0;
    w_occ_nxt = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (RB_Flush_Valid) begin
        w_v_nxt[i] = 1'b0;
      end else if (i == 0) begin
        w_v_nxt[i] = w_load | (r_v[0] & ~w_adv[0]);
      end else begin
        w_v_nxt[i] = (r_v[i-1] & w_adv[i-1]) | (r_v[i] & ~w_adv[i]);
      end
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_v   <= '0;
      r_occ <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
    end
  end

  // Data path follows the valid moves; a flush only clears valids.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rs <= '0;
      r_rt <= '0;
      for (int i = 0; i < N_STAGES; i++) r_tag[i] <= '0;
      for (int i = 1; i < N_STAGES; i++) r_prod[i] <= '0;
    end else begin
      if (w_load) begin
        r_rs     <= IssueQue_Rs_Data;
        r_rt     <= IssueQue_Rt_Data;
        r_tag[0] <= IssueQue_Rd_Tag;
      end
      if (r_v[0] & w_adv[0]) begin
        r_prod[1] <= w_prod32[15:0];
        r_tag[1]  <= r_tag[0];
      end
      for (int i = 2; i < N_STAGES; i++) begin
        if (r_v[i-1] & w_adv[i-1]) begin
          r_prod[i] <= r_prod[i-1];
          r_tag[i]  <= r_tag[i-1];
        end
      end
    end
  end

  assign Mult_Ready     = w_ready;
  assign Mult_Cdb_Req   = r_v[K];
  assign Mult_Cdb_Data  = r_prod[K];
  assign Mult_Cdb_Tag   = r_tag[K];
  assign Mult_Occupancy = r_occ;

endmodule

// File: tb/tb_mult_exec_unit.sv
// Directed-vector bench for mult_exec_unit (N_STAGES=4).
module tb_mult_exec_unit;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        IssueQue_Ready;
  logic [15:0] IssueQue_Rs_Data;
  logic [15:0] IssueQue_Rt_Data;
  logic [4:0]  IssueQue_Rd_Tag;
  logic        Issueblk_Issue;
  logic        Mult_Ready;
  logic        Mult_Cdb_Req;
  logic [15:0] Mult_Cdb_Data;
  logic [4:0]  Mult_Cdb_Tag;
  logic        Cdb_Grant;
  logic        RB_Flush_Valid;
  logic [2:0]  Mult_Occupancy;

  int n_chk  = 0;
  int n_pass = 0;

  mult_exec_unit #(.N_STAGES(4), .OCC_W(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .IssueQue_Ready(IssueQue_Ready), .IssueQue_Rs_Data(IssueQue_Rs_Data),
    .IssueQue_Rt_Data(IssueQue_Rt_Data), .IssueQue_Rd_Tag(IssueQue_Rd_Tag),
    .Issueblk_Issue(Issueblk_Issue), .Mult_Ready(Mult_Ready),
    .Mult_Cdb_Req(Mult_Cdb_Req), .Mult_Cdb_Data(Mult_Cdb_Data),
    .Mult_Cdb_Tag(Mult_Cdb_Tag), .Cdb_Grant(Cdb_Grant),
    .RB_Flush_Valid(RB_Flush_Valid), .Mult_Occupancy(Mult_Occupancy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic iss, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [4:0] tag, input logic gnt, input logic fl);
    Issueblk_Issue   = iss;
    IssueQue_Ready   = iss;
    IssueQue_Rs_Data = rs;
    IssueQue_Rt_Data = rt;
    IssueQue_Rd_Tag  = tag;
    Cdb_Grant        = gnt;
    RB_Flush_Valid   = fl;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_ready", Mult_Ready, 1);
    chk("rst_req",   Mult_Cdb_Req, 0);
    chk("rst_data",  Mult_Cdb_Data, 0);
    chk("rst_tag",   Mult_Cdb_Tag, 0);
    chk("rst_occ",   Mult_Occupancy, 0);
    Rst = 1'b1;
    tick();

    // Single issue, grant held: 3*5 with tag 7
    drive(1, 16'h0003, 16'h0005, 5'd7, 1, 0);
    tick();
    chk("t1_occ_load", Mult_Occupancy, 1);
    drive(0, 0, 0, 0, 1, 0);
    tick(); tick();
    chk("t1_req_early", Mult_Cdb_Req, 0);
    tick();
    chk("t1_req",  Mult_Cdb_Req, 1);
    chk("t1_data", Mult_Cdb_Data, 16'h000F);
    chk("t1_tag",  Mult_Cdb_Tag, 7);
    chk("t1_occ",  Mult_Occupancy, 1);
    tick();
    chk("t1_req_done", Mult_Cdb_Req, 0);
    chk("t1_occ_done", Mult_Occupancy, 0);

    // Back-to-back issues with grant held
    for (int c = 0; c < 8; c++) begin
      drive(c < 4, 16'(c + 1), 16'd10, 5'(c + 1), 1, 0);
      chk("t2_ready", Mult_Ready, 1);
      tick();
      if (c >= 3 && c < 7) begin
        chk("t2_req",  Mult_Cdb_Req, 1);
        chk("t2_tag",  Mult_Cdb_Tag, 32'(c - 2));
        chk("t2_data", Mult_Cdb_Data, 32'((c - 2) * 10));
      end
    end
    chk("t2_req_end", Mult_Cdb_Req, 0);
    chk("t2_occ_end", Mult_Occupancy, 0);

    // Fill the pipe with no grant, stall, then drain
    for (int k = 0; k < 4; k++) begin
      drive(1, 16'(k + 1), 16'd3, 5'(11 + k), 0, 0);
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      drive(1, 16'd7, 16'd7, 5'd31, 0, 0);
      chk("t3_ready_full", Mult_Ready, 0);
      tick();
      chk("t3_occ",  Mult_Occupancy, 4);
      chk("t3_req",  Mult_Cdb_Req, 1);
      chk("t3_tag",  Mult_Cdb_Tag, 11);
      chk("t3_data", Mult_Cdb_Data, 3);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      chk("t3_ready_gnt", Mult_Ready, 1);
      chk("t3_drain_req",  Mult_Cdb_Req, 1);
      chk("t3_drain_tag",  Mult_Cdb_Tag, 32'(11 + k));
      chk("t3_drain_data", Mult_Cdb_Data, 32'(3 * (k + 1)));
      tick();
    end
    chk("t3_req_end", Mult_Cdb_Req, 0);
    chk("t3_occ_end", Mult_Occupancy, 0);

    // Bubble collapse: A, two idle cycles, B, grant low
    drive(1, 16'd2, 16'd2, 5'd5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 16'd3, 16'd3, 5'd6, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("t4_occ",   Mult_Occupancy, 2);
    chk("t4_ready", Mult_Ready, 1);
    chk("t4_tagA",  Mult_Cdb_Tag, 5);
    chk("t4_dataA", Mult_Cdb_Data, 4);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_reqB",  Mult_Cdb_Req, 1);
    chk("t4_tagB",  Mult_Cdb_Tag, 6);
    chk("t4_dataB", Mult_Cdb_Data, 9);
    chk("t4_occB",  Mult_Occupancy, 1);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("t4_occ_end", Mult_Occupancy, 0);

    // Flush with three in flight, plus same-cycle issue and grant
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'd1, 16'd1, 5'(20 + k), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_occ_pre", Mult_Occupancy, 3);
    drive(1, 16'd4, 16'd4, 5'd23, 1, 1);
    chk("t5_req_pre", Mult_Cdb_Req, 1);
    chk("t5_tag_pre", Mult_Cdb_Tag, 20);
    tick();
    chk("t5_req_post", Mult_Cdb_Req, 0);
    chk("t5_occ_post", Mult_Occupancy, 0);
    drive(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_no_result", Mult_Cdb_Req, 0);
    end

    // Full-width product: 0xFFFF * 2
    drive(1, 16'hFFFF, 16'h0002, 5'd9, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
`ifdef MULT_SIGNED_EN
    chk("t6_prod32", dut.w_prod32, 32'hFFFFFFFE);
`else
    chk("t6_prod32", dut.w_prod32, 32'h0001FFFE);
`endif
    tick(); tick(); tick();
    chk("t6_req",  Mult_Cdb_Req, 1);
    chk("t6_data", Mult_Cdb_Data, 16'hFFFE);
    chk("t6_tag",  Mult_Cdb_Tag, 9);
    tick();
    chk("t6_occ_end", Mult_Occupancy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
